// File: rtl/digit_chain_pkg.sv
// rtl/digit_chain_pkg.sv - shared state type, default digit width and clamp helper for digit_chain_counter
package digit_chain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_DW = 4;

  // Caller zero-extends to 32 bits and truncates the result back to the digit width.
  function automatic logic [31:0] clamp(input logic [31:0] init, input logic [31:0] lim);
    return (init > lim) ? lim : init;
  endfunction

endpackage

// File: rtl/digit_chain_counter_digit_cell.sv
// rtl/digit_chain_counter_digit_cell.sv - one digit of the cascaded counter (module digit_cell)
module digit_cell
  import digit_chain_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_init,
  input  logic [DW-1:0] i_limit,
  input  logic          i_step,
  input  logic          i_wrap,
  input  logic [DW-1:0] i_wrap_to,
`ifdef DIGIT_CHAIN_UPCOUNT_EN
  input  logic          i_dir,
  output logic          o_at_limit,
`endif
  output logic [DW-1:0] o_val,
  output logic          o_zero
);

  logic [DW-1:0] r_val;
  logic [DW-1:0] w_init_c;
  logic [DW-1:0] w_step_val;

  assign w_init_c = DW'(clamp(32'(i_init), 32'(i_limit)));

  // Next value for a single step; a digit above its limit just keeps decrementing.
  always_comb begin
    w_step_val = (r_val == '0) ? i_limit : r_val - 1'b1;
`ifdef DIGIT_CHAIN_UPCOUNT_EN
    if (i_dir) begin
      w_step_val = (r_val == i_limit) ? '0 : r_val + 1'b1;
    end
`endif
  end

  // Digit register: reset and load both take the clamped init value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= w_init_c;
    end else if (i_load) begin
      r_val <= w_init_c;
    end else if (i_wrap) begin
      r_val <= i_wrap_to;
    end else if (i_step) begin
      r_val <= w_step_val;
    end
  end

  assign o_val  = r_val;
  assign o_zero = (r_val == '0);
`ifdef DIGIT_CHAIN_UPCOUNT_EN
  assign o_at_limit = (r_val == i_limit);
`endif

endmodule

// File: rtl/digit_chain_counter.sv
// rtl/digit_chain_counter.sv - N-digit cascaded counter with FSM and terminal detect; DIGIT_CHAIN_UPCOUNT_EN adds dir
module digit_chain_counter
  import digit_chain_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int DW      = DEFAULT_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic                  wrap_en,
`ifdef DIGIT_CHAIN_UPCOUNT_EN
  input  logic                  dir,
`endif
  input  logic [NDIGITS*DW-1:0] init_val,
  input  logic [NDIGITS*DW-1:0] limit,
  output logic [NDIGITS*DW-1:0] val,
  output logic                  borrow_out,
  output logic                  done,
  output logic                  running
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_borrow;
  logic                 w_borrow_nxt;
  logic                 w_count;
  logic                 w_wrap;
  logic                 w_dir;
  logic                 w_terminal;
  logic [NDIGITS-1:0]   w_zero;
  logic [NDIGITS-1:0]   w_edge;
  logic [NDIGITS-1:0]   w_step;

`ifdef DIGIT_CHAIN_UPCOUNT_EN
  logic [NDIGITS-1:0]   w_at_limit;
  assign w_dir  = dir;
  assign w_edge = dir ? w_at_limit : w_zero;
`else
  assign w_dir  = 1'b0;
  assign w_edge = w_zero;
`endif

  // The whole chain sits on its edge value: all-zero going down, all-at-limit going up.
  assign w_terminal = &w_edge;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    if (g == 0) begin : g_first
      assign w_step[g] = w_count;
    end else begin : g_rest
      assign w_step[g] = w_count & (&w_edge[g-1:0]);
    end

    digit_cell #(.DW(DW)) u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_load    (load),
      .i_init    (init_val[g*DW +: DW]),
      .i_limit   (limit[g*DW +: DW]),
      .i_step    (w_step[g]),
      .i_wrap    (w_wrap),
      .i_wrap_to (w_dir ? {DW{1'b0}} : limit[g*DW +: DW]),
`ifdef DIGIT_CHAIN_UPCOUNT_EN
      .i_dir     (dir),
      .o_at_limit(w_at_limit[g]),
`endif
      .o_val     (val[g*DW +: DW]),
      .o_zero    (w_zero[g])
    );
  end

  // State and borrow pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_borrow <= w_borrow_nxt;
    end
  end

  // Command priority load > stop > start > tick; a tick only counts in RUN with no command.
  always_comb begin
    w_state_nxt  = r_state;
    w_count      = 1'b0;
    w_wrap       = 1'b0;
    w_borrow_nxt = 1'b0;
    if (load) begin
      w_state_nxt = IDLE;
    end else if (stop) begin
      if (r_state == RUN) w_state_nxt = IDLE;
    end else if (start) begin
      if (r_state != RUN) w_state_nxt = RUN;
    end else if (tick && (r_state == RUN)) begin
      if (w_terminal) begin
        if (wrap_en) begin
          w_wrap       = 1'b1;
          w_borrow_nxt = 1'b1;
        end else begin
          w_state_nxt = DONE;
        end
      end else begin
        w_count = 1'b1;
      end
    end
  end

  assign borrow_out = r_borrow;
  assign done       = (r_state == DONE);
  assign running    = (r_state == RUN);

endmodule

// File: tb/tb_digit_chain_counter.sv
// tb/tb_digit_chain_counter.sv - directed and random checks of digit_chain_counter against a mixed-radix model
module tb_digit_chain_counter;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int W  = ND * DW;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick, start, stop, load, wrap_en;
  logic         dir;
  logic [W-1:0] init_val, limit, val;
  logic         borrow_out, done, running;

  digit_chain_counter #(.NDIGITS(ND), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .load      (load),
    .wrap_en   (wrap_en),
`ifdef DIGIT_CHAIN_UPCOUNT_EN
    .dir       (dir),
`endif
    .init_val  (init_val),
    .limit     (limit),
    .val       (val),
    .borrow_out(borrow_out),
    .done      (done),
    .running   (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the count is one integer in mixed radix (digit i has radix limit_i+1).
  int m_n;
  int m_st;   // 0 idle, 1 run, 2 done
  bit m_borrow;

  function automatic int radix_total(input logic [W-1:0] lim);
    int m = 1;
    for (int i = 0; i < ND; i++) m = m * (int'(lim[i*DW +: DW]) + 1);
    return m;
  endfunction

  function automatic int to_int(input logic [W-1:0] v, input logic [W-1:0] lim);
    int n = 0;
    int mult = 1;
    for (int i = 0; i < ND; i++) begin
      int d = int'(v[i*DW +: DW]);
      int l = int'(lim[i*DW +: DW]);
      if (d > l) d = l;
      n = n + d * mult;
      mult = mult * (l + 1);
    end
    return n;
  endfunction

  function automatic logic [W-1:0] to_vec(input int n, input logic [W-1:0] lim);
    logic [W-1:0] r = '0;
    int rem = n;
    for (int i = 0; i < ND; i++) begin
      int rad = int'(lim[i*DW +: DW]) + 1;
      r[i*DW +: DW] = DW'(rem % rad);
      rem = rem / rad;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ":val"},     val,             to_vec(m_n, limit));
    check({ctx, ":borrow"},  W'(borrow_out),  W'(m_borrow));
    check({ctx, ":done"},    W'(done),        W'(m_st == 2));
    check({ctx, ":running"}, W'(running),     W'(m_st == 1));
  endtask

  task automatic model_reset();
    m_n = to_int(init_val, limit);
    m_st = 0;
    m_borrow = 0;
  endtask

  task automatic model_step();
    int  m  = radix_total(limit);
    bit  up = 1'b0;
    bit  term;
`ifdef DIGIT_CHAIN_UPCOUNT_EN
    up = dir;
`endif
    m_borrow = 0;
    if (load) begin
      m_n = to_int(init_val, limit);
      m_st = 0;
    end else if (stop) begin
      if (m_st == 1) m_st = 0;
    end else if (start) begin
      if (m_st != 1) m_st = 1;
    end else if (tick && m_st == 1) begin
      term = up ? (m_n == m - 1) : (m_n == 0);
      if (term) begin
        if (wrap_en) begin
          m_n = up ? 0 : m - 1;
          m_borrow = 1;
        end else begin
          m_st = 2;
        end
      end else begin
        m_n = up ? m_n + 1 : m_n - 1;
      end
    end
  endtask

  task automatic cycle(input string ctx, input bit l, input bit sp, input bit st, input bit tk);
    load = l; stop = sp; start = st; tick = tk;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(ctx);
    load = 0; stop = 0; start = 0; tick = 0;
  endtask

  logic [W-1:0] exp_down [4];

  initial begin
    rst = 1; tick = 0; start = 0; stop = 0; load = 0; wrap_en = 0; dir = 0;
    init_val = 16'h0003; limit = 16'h5959;
    #12;
    model_reset();
    check_all("reset");
    check("reset_val_const", val, 16'h0003);
    @(negedge clk);
    rst = 0;

    // countdown to DONE
    cycle("start", 0, 0, 1, 0);
    exp_down[0] = 16'h0002; exp_down[1] = 16'h0001;
    exp_down[2] = 16'h0000; exp_down[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      cycle("down", 0, 0, 0, 1);
      check("down_const", val, exp_down[i]);
    end
    check("done_const", W'(done), W'(1'b1));

    // cascade borrow
    init_val = 16'h0100;
    cycle("ld_0100", 1, 0, 0, 0);
    cycle("start2", 0, 0, 1, 0);
    cycle("cascade", 0, 0, 0, 1);
    check("cascade_const", val, 16'h0059);

    // terminal wrap
    init_val = 16'h0000; wrap_en = 1;
    cycle("ld_0000", 1, 0, 0, 0);
    cycle("start3", 0, 0, 1, 0);
    cycle("wrap", 0, 0, 0, 1);
    check("wrap_val_const", val, 16'h5959);
    check("wrap_borrow_const", W'(borrow_out), W'(1'b1));
    check("wrap_run_const", W'(running), W'(1'b1));
    cycle("wrap_after", 0, 0, 0, 0);
    check("borrow_drop_const", W'(borrow_out), W'(1'b0));

    // priority
    init_val = 16'h0321;
    cycle("load_tick", 1, 0, 0, 1);
    check("load_tick_const", val, 16'h0321);
    check("load_tick_idle", W'(running), W'(1'b0));
    cycle("start_tick", 0, 0, 1, 1);
    check("start_tick_val", val, 16'h0321);
    check("start_tick_run", W'(running), W'(1'b1));

    // clamp then async reset mid-run
    init_val = 16'h0099;
    cycle("clamp", 1, 0, 0, 0);
    check("clamp_const", val, 16'h0059);
    cycle("start4", 0, 0, 1, 0);
    cycle("t1", 0, 0, 0, 1);
    cycle("t2", 0, 0, 0, 1);
    #1 rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst_const", val, 16'h0059);
    @(negedge clk);
    rst = 0;

`ifdef DIGIT_CHAIN_UPCOUNT_EN
    dir = 1; wrap_en = 1;
    init_val = 16'h0059;
    cycle("up_ld", 1, 0, 0, 0);
    cycle("up_start", 0, 0, 1, 0);
    cycle("up_tick", 0, 0, 0, 1);
    check("up_carry_const", val, 16'h0100);
    init_val = 16'h5959;
    cycle("up_ld2", 1, 0, 0, 0);
    cycle("up_start2", 0, 0, 1, 0);
    cycle("up_wrap", 0, 0, 0, 1);
    check("up_wrap_const", val, 16'h0000);
    check("up_borrow_const", W'(borrow_out), W'(1'b1));
    dir = 0;
`endif

    // randomized phase
    for (int k = 0; k < 500; k++) begin
      bit l, sp, st, tk;
      l  = ($urandom_range(0, 99) < 4);
      sp = ($urandom_range(0, 99) < 3);
      st = ($urandom_range(0, 99) < 8);
      tk = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < ND; i++) limit[i*DW +: DW] = DW'($urandom_range(0, 9));
        init_val = W'($urandom);
        l = 1;
      end
      if ($urandom_range(0, 19) == 0) wrap_en = ~wrap_en;
`ifdef DIGIT_CHAIN_UPCOUNT_EN
      if ($urandom_range(0, 19) == 0) dir = ~dir;
`endif
      cycle("rand", l, sp, st, tk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_chain_counter.md
# digit_chain_counter

Parametrised multi-digit cascaded down counter with per-digit wrap limits, load, start/stop control and terminal-count detection. It generalises the single-digit borrow counter into an N-digit chain, such as a mm:ss countdown timer driven by a 1 Hz tick. It sits between the clock-divider tick source and the seven-segment display driver in the lab timer designs.

## Interface
- NDIGITS, 4, number of cascaded digits (1..8)
- DW, 4, bits per digit

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle count-enable pulse
- start  in  1  pulse; IDLE/DONE -> RUN
- stop  in  1  pulse; RUN -> IDLE, value held
- load  in  1  pulse; copy init_val into the counter
- wrap_en  in  1  1: wrap at zero and keep running; 0: stop at zero
- init_val  in  NDIGITS*DW  reset/load value, digit 0 in LSBs
- limit  in  NDIGITS*DW  per-digit wrap value (for example 9 or 5)
- val  out  NDIGITS*DW  current count, registered
- borrow_out  out  1  one-cycle pulse on a full-chain wrap
- done  out  1  high while in DONE
- running  out  1  high while in RUN

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - DONE
- Transitions:
  - IDLE --start--> RUN
  - RUN --stop--> IDLE
  - RUN --terminal tick with wrap_en=0--> DONE
  - DONE --start--> RUN
  - DONE --load--> IDLE
  - IDLE --load--> IDLE
- Count rule, in RUN on tick:
  - Digit 0 always steps.
  - Digit i steps only when digits 0..i-1 are all zero.
  - A stepping digit at 0 becomes limit[i]; otherwise it becomes val-1.
- Terminal tick: a tick in RUN while val is all-zero.
  - wrap_en=1: every digit loads its limit, borrow_out pulses, state stays RUN.
  - wrap_en=0: val stays all-zero and the state goes to DONE.
- Reaching all-zero through a normal decrement does not change state. DONE is entered only on the following tick.
- Ticks in IDLE or DONE are ignored.
- Load takes init_val digit-wise. Any digit with init > limit is clamped to limit[i]. This clamping applies at reset as well.
- Any digit with val > limit (because limit changed at run time) steps to val-1 as normal; no correction is applied.
- Priority in one cycle: load > stop > start > tick.
  - load in RUN updates val and moves to IDLE.
  - start with tick in the same cycle: the tick is ignored.
- All arithmetic is unsigned per digit. There is no carry into or out of the DW bits other than the borrow chain.

## Timing
- Reset values:
  - val = clamped init_val
  - state IDLE
  - borrow_out = 0, done = 0, running = 0
- All outputs are registered. The effect of an input sampled at edge k is visible after edge k.
- Latency from tick to val update: 1 cycle.
- borrow_out is high for exactly the cycle after the terminal tick.
- done rises in the cycle after the terminal tick and is held until start or load.
- rst asserted mid-RUN forces reset values immediately, asynchronously.
- Back-to-back ticks, one per cycle, are supported with no lost counts.

## Configuration
- DIGIT_CHAIN_UPCOUNT_EN
- Defined:
  - Adds input dir (1 bit) between wrap_en and init_val.
  - dir=1 counts up: digit i steps when all lower digits equal their limits; a stepping digit at limit goes to 0, otherwise val+1.
  - The terminal condition in up mode is every digit at its limit. The wrap target is all-zero.
  - dir=0 is identical to the default behaviour.
  - A dir change takes effect on the next tick.
- Undefined: no dir port; the counter is down-only.

## Structure
- Package digit_chain_pkg holds:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - default DW constant
  - clamp function: min(init, limit)
- Sub-module digit_cell is instantiated NDIGITS times in a generate loop.
  - Inputs: step, wrap_to, dir (under the macro)
  - Output: zero (or at_limit), fed to the next cell's step logic
- The top level holds the FSM, terminal detection and the borrow_out register.

## Test plan
- Reset, load, wrap: NDIGITS=4, limit=5959, init_val=0003, start, 4 ticks with wrap_en=0 -> val 0002, 0001, 0000, then done=1, val=0000.
- Cascade borrow: init_val=0100, limit=5959, one tick -> val 0059.
- Terminal wrap: init_val=0000, wrap_en=1, start, tick -> val 5959, borrow_out high for 1 cycle, running stays 1.
- Priority: load together with tick in RUN -> val=init_val, state IDLE; start together with tick in IDLE -> running=1, val unchanged.
- Clamp and async reset: init_val=0099 with limit=5959 -> val 0059; rst asserted mid-RUN -> val, state and flags return to reset values with no clock edge.
- Up mode (DIGIT_CHAIN_UPCOUNT_EN, dir=1): init_val=0059, tick -> 0100; init_val=5959, tick -> 0000 with borrow_out.
